// File: rtl/multicycle_ctrl_if.sv
// Control/datapath bundle for the multi-cycle RV32I core.
// master = controller, slave = datapath/memory side.
interface multicycle_ctrl_if;
    logic [6:0]  opcode;
    logic        br_taken;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        mem_is_fetch;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic [1:0]  alu_a_sel;
    logic        alu_b_sel;
    logic [1:0]  alu_op;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic        illegal;
    logic        timeout;
    logic [2:0]  state;
    logic [31:0] instret;

    modport master (
        input  opcode, br_taken, mem_ready,
        output mem_req, mem_we, mem_is_fetch, ir_we, pc_we, pc_sel, alu_a_sel, alu_b_sel,
               alu_op, reg_we, wb_sel, illegal, timeout, state, instret
    );
    modport slave (
        output opcode, br_taken, mem_ready,
        input  mem_req, mem_we, mem_is_fetch, ir_we, pc_we, pc_sel, alu_a_sel, alu_b_sel,
               alu_op, reg_we, wb_sel, illegal, timeout, state, instret
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch/decode/exec/mem/wb sequencing, memory handshake,
// illegal-opcode and memory-timeout detection, retired-instruction counter.
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT_MAX = 200
) (
    input  logic              clk,
    input  logic              rst_n,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
        S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd7
    } state_e;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_AUI  = 7'b0010111;

    state_e      state_q, state_d;
    logic        illegal_q, illegal_d;
    logic        timeout_q, timeout_d;
    logic [31:0] instret_q, instret_d;
    logic [7:0]  wcnt_q, wcnt_d;

    logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_aui, legal;
    logic mem_req, mem_we, mem_is_fetch, ir_we, pc_we, alu_b_sel, reg_we, wait_hit;
    logic [1:0] pc_sel, alu_a_sel, alu_op, wb_sel;

    assign is_r    = (bus.opcode == OP_R);
    assign is_i    = (bus.opcode == OP_I);
    assign is_ld   = (bus.opcode == OP_LD);
    assign is_st   = (bus.opcode == OP_ST);
    assign is_br   = (bus.opcode == OP_BR);
    assign is_jal  = (bus.opcode == OP_JAL);
    assign is_jalr = (bus.opcode == OP_JALR);
    assign is_lui  = (bus.opcode == OP_LUI);
    assign is_aui  = (bus.opcode == OP_AUI);
    assign legal   = is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr | is_lui | is_aui;

    always_comb begin
        mem_req = 1'b0; mem_we = 1'b0; mem_is_fetch = 1'b0; ir_we = 1'b0;
        pc_we = 1'b0; pc_sel = 2'd0; reg_we = 1'b0; wb_sel = 2'd0;
        alu_a_sel = 2'd0; alu_b_sel = 1'b0; alu_op = 2'd0;
        // ALU is unregistered, so its operand selects hold through MEM and WB
        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            if (is_r)                  alu_op = 2'd1;
            if (is_i)                  begin alu_b_sel = 1'b1; alu_op = 2'd1; end
            if (is_ld | is_st | is_jalr) alu_b_sel = 1'b1;
            if (is_lui)                begin alu_a_sel = 2'd2; alu_b_sel = 1'b1; end
            if (is_aui)                begin alu_a_sel = 2'd1; alu_b_sel = 1'b1; end
            if (is_br)                 alu_op = 2'd2;
        end
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1; mem_is_fetch = 1'b1; ir_we = bus.mem_ready;
            end
            S_EXEC: begin
                if (is_br)   begin pc_we = 1'b1; pc_sel = {1'b0, bus.br_taken}; end
                if (is_jal)  begin pc_we = 1'b1; pc_sel = 2'd1; reg_we = 1'b1; wb_sel = 2'd2; end
                if (is_jalr) begin pc_we = 1'b1; pc_sel = 2'd2; reg_we = 1'b1; wb_sel = 2'd2; end
            end
            S_MEM: begin
                mem_req = 1'b1; mem_we = is_st; pc_we = is_st & bus.mem_ready;
            end
            S_WB: begin
                reg_we = 1'b1; wb_sel = is_ld ? 2'd1 : 2'd0; pc_we = 1'b1;
            end
            default: ;
        endcase
    end

    // ready in the final allowed cycle wins over the timeout
    assign wait_hit = mem_req & ~bus.mem_ready &
                      (({1'b0, wcnt_q} + 9'd1) == 9'(TIMEOUT_MAX));

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        instret_d = instret_q + {31'd0, pc_we};
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (legal) state_d = S_EXEC;
                else begin illegal_d = 1'b1; state_d = S_HALT; end
            end
            S_EXEC:   state_d = (is_br | is_jal | is_jalr) ? S_FETCH :
                                (is_ld | is_st)            ? S_MEM   : S_WB;
            S_MEM:    if (bus.mem_ready) state_d = is_ld ? S_WB : S_FETCH;
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_HALT;
        endcase
        if (wait_hit) begin
            timeout_d = 1'b1;
            state_d   = S_HALT;
        end
        wcnt_d = wcnt_q;
        if ((state_d == S_FETCH || state_d == S_MEM) && state_d != state_q) wcnt_d = 8'd0;
        else if (mem_req && !bus.mem_ready)                                 wcnt_d = wcnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            instret_q <= 32'd0;
            wcnt_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            instret_q <= instret_d;
            wcnt_q    <= wcnt_d;
        end
    end

    assign bus.mem_req      = mem_req;
    assign bus.mem_we       = mem_we;
    assign bus.mem_is_fetch = mem_is_fetch;
    assign bus.ir_we        = ir_we;
    assign bus.pc_we        = pc_we;
    assign bus.pc_sel       = pc_sel;
    assign bus.alu_a_sel    = alu_a_sel;
    assign bus.alu_b_sel    = alu_b_sel;
    assign bus.alu_op       = alu_op;
    assign bus.reg_we       = reg_we;
    assign bus.wb_sel       = wb_sel;
    assign bus.illegal      = illegal_q;
    assign bus.timeout      = timeout_q;
    assign bus.state        = state_q;
    assign bus.instret      = instret_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: instruction-level model expands directed programs into
// per-cycle stimulus and expected outputs, checked every cycle; plus literal pins.
module tb_multicycle_ctrl;
    localparam int TM = 200;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_AUI  = 7'b0010111;

    typedef struct packed {
        logic [2:0]  state;
        logic        mem_req, mem_we, mem_is_fetch, ir_we, pc_we;
        logic [1:0]  pc_sel, alu_a_sel;
        logic        alu_b_sel;
        logic [1:0]  alu_op;
        logic        reg_we;
        logic [1:0]  wb_sel;
        logic        illegal, timeout;
        logic [31:0] instret;
    } exp_t;

    typedef struct {
        logic [6:0] opc;
        logic       br;
        logic       rdy;
        exp_t       e;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n;
    multicycle_ctrl_if bus();

    multicycle_ctrl #(.TIMEOUT_MAX(TM)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    rec_t        q[$];
    bit          m_ill, m_to, idle_rdy;
    int unsigned m_cnt;
    int          checks = 0;
    int          errors = 0;

    function automatic exp_t base(input logic [2:0] st);
        exp_t e;
        e = '0;
        e.state = st; e.illegal = m_ill; e.timeout = m_to; e.instret = m_cnt;
        return e;
    endfunction

    task automatic push(input logic [6:0] opc, input logic br, input logic rdy, input exp_t e);
        rec_t r;
        r.opc = opc; r.br = br; r.rdy = rdy; r.e = e;
        q.push_back(r);
        if (e.pc_we) m_cnt++;
    endtask

    // operand/op selects each instruction class uses while its ALU result is live
    task automatic alu_of(input logic [6:0] opc, output logic [1:0] a, output logic b,
                          output logic [1:0] op);
        a = 2'd0; b = 1'b0; op = 2'd0;
        case (opc)
            OP_R:                 op = 2'd1;
            OP_I:                 begin b = 1'b1; op = 2'd1; end
            OP_LD, OP_ST, OP_JALR: b = 1'b1;
            OP_LUI:               begin a = 2'd2; b = 1'b1; end
            OP_AUI:               begin a = 2'd1; b = 1'b1; end
            OP_BR:                op = 2'd2;
            default: ;
        endcase
    endtask

    task automatic halt(input logic [6:0] opc, input int n);
        for (int i = 0; i < n; i++) push(opc, 1'b0, idle_rdy, base(3'd7));
    endtask

    task automatic start_prog();
        m_ill = 0; m_to = 0; m_cnt = 0;
        push(7'd0, 1'b0, 1'b0, base(3'd0));
    endtask

    // fw/mw: cycles memory withholds ready; >= TM means never. cut>0 stops after cut MEM cycles.
    task automatic run_instr(input logic [6:0] opc, input logic br = 1'b0, input int fw = 0,
                             input int mw = 0, input int cut = 0);
        exp_t e;
        logic [1:0] a, op;
        logic b, rdy;
        bit legal, ctl, mem;
        int n;
        legal = opc inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUI};
        ctl   = opc inside {OP_BR, OP_JAL, OP_JALR};
        mem   = opc inside {OP_LD, OP_ST};
        alu_of(opc, a, b, op);
        n = (fw >= TM) ? TM : fw + 1;
        for (int i = 0; i < n; i++) begin
            e = base(3'd1); e.mem_req = 1; e.mem_is_fetch = 1; e.ir_we = (i == fw);
            push(opc, br, e.ir_we, e);
        end
        if (fw >= TM) begin m_to = 1; halt(opc, 3); return; end
        push(opc, br, idle_rdy, base(3'd2));
        if (!legal) begin m_ill = 1; halt(opc, 4); return; end
        e = base(3'd3); e.alu_a_sel = a; e.alu_b_sel = b; e.alu_op = op;
        if (opc == OP_BR)   begin e.pc_we = 1; e.pc_sel = br ? 2'd1 : 2'd0; end
        if (opc == OP_JAL)  begin e.pc_we = 1; e.pc_sel = 2'd1; e.reg_we = 1; e.wb_sel = 2'd2; end
        if (opc == OP_JALR) begin e.pc_we = 1; e.pc_sel = 2'd2; e.reg_we = 1; e.wb_sel = 2'd2; end
        push(opc, br, idle_rdy, e);
        if (ctl) return;
        if (mem) begin
            n = (mw >= TM) ? TM : mw + 1;
            if (cut > 0) n = cut;
            for (int i = 0; i < n; i++) begin
                rdy = (i == mw);
                e = base(3'd4); e.alu_a_sel = a; e.alu_b_sel = b; e.alu_op = op;
                e.mem_req = 1; e.mem_we = (opc == OP_ST); e.pc_we = (opc == OP_ST) && rdy;
                push(opc, br, rdy, e);
            end
            if (cut > 0) return;
            if (mw >= TM) begin m_to = 1; halt(opc, 3); return; end
            if (opc == OP_ST) return;
        end
        e = base(3'd5); e.alu_a_sel = a; e.alu_b_sel = b; e.alu_op = op;
        e.reg_we = 1; e.wb_sel = (opc == OP_LD) ? 2'd1 : 2'd0; e.pc_we = 1;
        push(opc, br, idle_rdy, e);
    endtask

    function automatic exp_t sample();
        exp_t g;
        g.state = bus.state; g.mem_req = bus.mem_req; g.mem_we = bus.mem_we;
        g.mem_is_fetch = bus.mem_is_fetch; g.ir_we = bus.ir_we; g.pc_we = bus.pc_we;
        g.pc_sel = bus.pc_sel; g.alu_a_sel = bus.alu_a_sel; g.alu_b_sel = bus.alu_b_sel;
        g.alu_op = bus.alu_op; g.reg_we = bus.reg_we; g.wb_sel = bus.wb_sel;
        g.illegal = bus.illegal; g.timeout = bus.timeout; g.instret = bus.instret;
        return g;
    endfunction

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
        end
    endtask

    // entered at a negedge; releases reset with the first (IDLE) record
    task automatic play();
        rec_t r;
        exp_t got;
        bit first;
        first = 1;
        while (q.size() > 0) begin
            r = q.pop_front();
            bus.opcode = r.opc; bus.br_taken = r.br; bus.mem_ready = r.rdy;
            if (first) begin rst_n = 1'b1; first = 0; end
            #1;
            got = sample();
            checks++;
            if (got !== r.e) begin
                errors++;
                $display("FAIL cycle t=%0t got=%h exp=%h", $time, got, r.e);
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.mem_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            lit("rst_state",   32'(bus.state),   0);
            lit("rst_mem_req", 32'(bus.mem_req), 0);
            lit("rst_instret", bus.instret,      0);
            lit("rst_illegal", 32'(bus.illegal), 0);
            lit("rst_timeout", 32'(bus.timeout), 0);
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; bus.opcode = '0; bus.br_taken = 1'b0; bus.mem_ready = 1'b0;
        idle_rdy = 0;
        @(negedge clk);
        do_reset();

        start_prog();
        idle_rdy = 1; run_instr(OP_I);
        idle_rdy = 0;
        run_instr(OP_LD, 1'b0, 3, 3);
        run_instr(OP_ST, 1'b0, 3, 3);
        run_instr(OP_BR, 1'b1);
        run_instr(OP_BR, 1'b0);
        run_instr(OP_R, 1'b0, 1);
        run_instr(OP_LUI);
        run_instr(OP_AUI, 1'b0, 2);
        run_instr(OP_JAL);
        run_instr(OP_JALR);
        run_instr(OP_I, 1'b0, TM - 1);
        run_instr(OP_ST, 1'b0, 0, TM - 1);
        idle_rdy = 1; run_instr(7'h7F);
        play();
        #1;
        lit("halt_state",   32'(bus.state),   7);
        lit("halt_illegal", 32'(bus.illegal), 1);
        lit("halt_instret", bus.instret,      12);
        lit("halt_mem_req", 32'(bus.mem_req), 0);
        @(negedge clk);

        idle_rdy = 0;
        do_reset();
        start_prog();
        run_instr(OP_I);
        run_instr(OP_LD, 1'b0, 0, 50, 3);
        play();
        #1;
        lit("mem_state",   32'(bus.state),   4);
        lit("mem_mem_req", 32'(bus.mem_req), 1);
        lit("mem_instret", bus.instret,      1);
        #2 rst_n = 1'b0;
        #1;
        lit("async_mem_req", 32'(bus.mem_req), 0);
        lit("async_state",   32'(bus.state),   0);
        lit("async_instret", bus.instret,      0);
        @(negedge clk);

        do_reset();
        start_prog();
        run_instr(OP_I, 1'b0, TM);
        play();
        #1;
        lit("to_state",   32'(bus.state),   7);
        lit("to_timeout", 32'(bus.timeout), 1);
        lit("to_mem_req", 32'(bus.mem_req), 0);
        lit("to_instret", bus.instret,      0);
        @(negedge clk);
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
